adder_share_arb: RTL
====================

// Module: adder_share_arb
// PURPOSE
//  Shares one 32-bit combinational adder (s = a + b mod 2^32, carry-in 0, no carry-out)
//  among NUM_REQ requesters. Round-robin arbitration, valid/ready handshake per requester.
//  Sequences each operation as capture -> compute -> respond, tagging the result with the
//  requester id. Sits between client blocks and the single adder instance so that only one
//  adder is placed.
// PARAMETERS
//  NUM_REQ  4                    number of requesters, 2..16
//  ID_W     $clog2(NUM_REQ)      width of requester id
//  CNT_W    16                   width of completed-operation counter
// PORTS
//  clk        in   1              clock, all state updates on rising edge
//  rst        in   1              synchronous reset, active-high
//  req_valid  in   NUM_REQ        bit i: requester i has operands pending
//  req_ready  out  NUM_REQ        bit i: requester i operands accepted this cycle (one-hot or 0)
//  req_a      in   NUM_REQ*32     operand a, requester i in bits [32*i+31:32*i]
//  req_b      in   NUM_REQ*32     operand b, same packing
//  rsp_valid  out  1              result available
//  rsp_ready  in   1              consumer accepts result
//  rsp_id     out  ID_W           id of requester that owns rsp_sum
//  rsp_sum    out  32             a + b mod 2^32
//  busy       out  1              high in any state other than IDLE
//  op_count   out  CNT_W          number of completed responses, wraps at 2^CNT_W
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): state=IDLE, rr_ptr=0, rsp_valid=0, rsp_sum=0, rsp_id=0,
//   op_count=0, busy=0. req_ready is forced to 0 in any cycle with rst=1.
//  Reset mid-operation: the in-flight operation is dropped and no response is produced.
//  FSM states: IDLE, CALC, RESP.
//   IDLE: if any req_valid, the winner g is the first set bit scanning rr_ptr, rr_ptr+1, ...
//    and wrapping modulo NUM_REQ. req_ready[g]=1 combinationally in the same cycle; all other
//    req_ready bits are 0. At the edge: op_a<=a[g], op_b<=b[g], id_q<=g,
//    rr_ptr<=(g+1) mod NUM_REQ, state->CALC. If no req_valid: stay in IDLE, rr_ptr unchanged.
//   CALC: sum_q <= adder(op_a, op_b). state->RESP. req_ready is 0.
//   RESP: rsp_valid=1, with rsp_sum=sum_q and rsp_id=id_q held stable until the handshake.
//    On rsp_valid & rsp_ready at the edge: op_count++, state->IDLE. Otherwise stay in RESP.
//    req_ready is 0.
//  Latency: request accepted at edge T, rsp_valid high from T+2. Minimum 3 cycles per
//   operation. A new request may be accepted in the IDLE cycle that follows the response.
//  Handshake rules:
//   - A requester must hold req_valid, req_a and req_b stable until it sees req_ready.
//   - The block never asserts req_ready to a requester whose req_valid is low.
//   - rsp_* outputs are registered. In IDLE and CALC, rsp_valid=0, and rsp_sum/rsp_id keep
//     their last values.
//  Arithmetic: 32-bit wrap-around. Overflow is discarded with no flag.
//   Example: 0xFFFF_FFFF + 1 = 0.
//  Fairness: a continuously valid requester is granted within NUM_REQ operations.
//  rr_ptr wraps from NUM_REQ-1 to 0. op_count wraps from 2^CNT_W-1 to 0.
//  busy = (state != IDLE).
// TESTING
//  1 rst held 2 cycles -> all outputs 0, req_ready=0 even with req_valid=4'hF.
//  2 Single req: req_valid=4'b0100, a=5, b=7 -> req_ready=4'b0100 same cycle;
//    rsp_valid 2 cycles later with rsp_sum=12, rsp_id=2; op_count=1 after the handshake.
//  3 Overflow: a=32'hFFFF_FFFF, b=1 -> rsp_sum=0. a=32'h8000_0000, b=32'h8000_0000 -> rsp_sum=0.
//  4 Round-robin: req_valid=4'hF held, each requester holding distinct operands ->
//    grant order 0,1,2,3,0. Each rsp_id matches, and each sum is correct.
//  5 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_sum and rsp_id stable,
//    req_ready=0 throughout, op_count unchanged. rsp_ready=1 -> IDLE on the next edge.
//  6 rst asserted while in CALC -> IDLE next cycle, rsp_valid never rises for the dropped op,
//    op_count=0, rr_ptr=0 (next grant goes to the lowest valid index).

Source files
------------

// File: rtl/adder_share_arb.sv
// adder_share_arb: one shared 32-bit adder time-multiplexed among NUM_REQ requesters.
// Each operation runs capture (IDLE) -> compute (CALC) -> respond (RESP). Requesters are
// picked round-robin, and the response carries the winning requester's id.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   req_valid/req_ready  per-requester handshake (req_ready is combinational, one-hot or 0)
//   req_a, req_b         packed operands, requester i in bits [32*i+31:32*i]
//   rsp_valid/rsp_ready  result handshake; rsp_id and rsp_sum held until it completes
//   busy                 high whenever the FSM is not in IDLE
//   op_count             completed responses, wraps
module adder_share_arb #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ),
    parameter int unsigned CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*32-1:0]   req_a,
    input  logic [NUM_REQ*32-1:0]   req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [31:0]             rsp_sum,
    output logic                    busy,
    output logic [CNT_W-1:0]        op_count
);

    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   id_q;
    logic [DW-1:0]     op_a_q;
    logic [DW-1:0]     op_b_q;
    logic [DW-1:0]     rsp_sum_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic              rsp_valid_q;
    logic [CNT_W-1:0]  op_count_q;

    logic              gnt_found;
    logic [ID_W-1:0]   gnt_id;
    logic [ID_W-1:0]   rr_ptr_d;
    logic [DW-1:0]     add_sum;
    int unsigned       idx;

    // Round-robin winner: first valid requester scanning upward from rr_ptr, with wrap.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        idx       = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(rr_ptr_q) + i) % NUM_REQ;
            if (!gnt_found && req_valid[idx[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_id    = idx[ID_W-1:0];
            end
        end
    end

    // Grant only while idle and out of reset, so a non-valid requester never sees ready.
    always_comb begin
        req_ready = '0;
        if (!rst && state_q == IDLE && gnt_found) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    assign rr_ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);

    // The single adder instance.
    assign add_sum = op_a_q + op_b_q;

    // FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_found) begin
                        op_a_q   <= req_a[DW*gnt_id +: DW];
                        op_b_q   <= req_b[DW*gnt_id +: DW];
                        id_q     <= gnt_id;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    // Response fields load only here so they keep their last values otherwise.
                    rsp_sum_q   <= add_sum;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        op_count_q  <= op_count_q + CNT_W'(1);
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;
    assign op_count  = op_count_q;
    assign busy      = (state_q != IDLE);

endmodule
